// File: rtl/mfp_input_debounce_pkg.sv
// Shared constants and helpers for the board input conditioning stage.
// Input vector layout is {SW[15:0], PB[4:0]}.
package mfp_input_debounce_pkg;

    localparam int unsigned MFP_N_SW            = 16;
    localparam int unsigned MFP_N_PB            = 5;
    localparam int unsigned MFP_INPUT_W         = MFP_N_SW + MFP_N_PB;
    localparam int unsigned MFP_DEBOUNCE_CYCLES = 250000;

    typedef enum logic [1:0] {
        DbHold,
        DbCount,
        DbAccept
    } db_action_e;

    // Decide what one bit's qualifier does this cycle.
    function automatic db_action_e db_action(input logic sync_lvl,
                                             input logic db_lvl,
                                             input logic cnt_full);
        if (sync_lvl == db_lvl) begin
            return DbHold;
        end else if (cnt_full) begin
            return DbAccept;
        end else begin
            return DbCount;
        end
    endfunction

endpackage

// File: rtl/mfp_debounce_bit.sv
// One input bit: 2-flop synchroniser, qualification counter, debounced level
// and registered 1-cycle rise/fall pulses that trail the level change by one cycle.
module mfp_debounce_bit
    import mfp_input_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = MFP_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic SI_ClkIn,
    input  logic SI_Reset_N,
    input  logic raw_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             db_dly_q, db_dly_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    db_action_e       action;

    always_comb begin
        s1_d     = raw_in;
        s2_d     = s1_q;
        cnt_d    = '0;
        db_d     = db_q;
        action   = db_action(s2_q, db_q, cnt_q == CntMax);

        case (action)
            DbCount:  cnt_d = cnt_q + CNT_W'(1);
            DbAccept: db_d  = ~db_q;
            default:  cnt_d = '0;
        endcase

        // Edge detect on the registered level so pulses land the cycle after db_out moves.
        db_dly_d = db_q;
        rise_d   = db_q & ~db_dly_q;
        fall_d   = ~db_q & db_dly_q;
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/mfp_input_debounce.sv
// Debounces the raw switch/pushbutton pins into the system clock domain.
// Every bit is an independent mfp_debounce_bit instance.
module mfp_input_debounce
    import mfp_input_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = MFP_INPUT_W,
    parameter int unsigned DEBOUNCE_CYCLES = MFP_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             SI_ClkIn,
    input  logic             SI_Reset_N,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mfp_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .SI_ClkIn   (SI_ClkIn),
            .SI_Reset_N (SI_Reset_N),
            .raw_in     (raw_in[i]),
            .db_out     (db_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_mfp_input_debounce.sv
// Directed bench for mfp_input_debounce with an 8-cycle debounce window.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mfp_input_debounce;

    localparam int unsigned WIDTH = 21;
    localparam int unsigned DB    = 8;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    int checks = 0;
    int errors = 0;

    mfp_input_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CNT_W)
    ) dut (
        .SI_ClkIn   (clk),
        .SI_Reset_N (rst_n),
        .raw_in     (raw),
        .db_out     (db),
        .rise_pulse (rise),
        .fall_pulse (fall)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        raw = '0;
        tick(14);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raw   = '1;
        tick(3);
        checks++;
        if (db !== '0) begin
            errors++;
            $display("FAIL reset_db: got %h expected %h", db, 21'h0);
        end
        checks++;
        if ((rise | fall) !== '0) begin
            errors++;
            $display("FAIL reset_pulses: got rise %h fall %h expected 0", rise, fall);
        end
        rst_n = 1'b1;
        tick(9);
        checks++;
        if (db !== '0) begin
            errors++;
            $display("FAIL reset_db_early: got %h expected %h", db, 21'h0);
        end
        tick(1);
        checks++;
        if (db !== 21'h1FFFFF || rise !== '0) begin
            errors++;
            $display("FAIL reset_db_up: got db %h rise %h expected db 1fffff rise 0", db, rise);
        end
        tick(1);
        checks++;
        if (rise !== 21'h1FFFFF || fall !== '0) begin
            errors++;
            $display("FAIL reset_rise: got rise %h fall %h expected 1fffff/0", rise, fall);
        end
        tick(1);
        checks++;
        if (rise !== '0) begin
            errors++;
            $display("FAIL reset_rise_width: got %h expected 0", rise);
        end
    endtask

    task automatic test_single_rise();
        settle();
        checks++;
        if (db !== '0) begin
            errors++;
            $display("FAIL settle_low: got %h expected 0", db);
        end
        raw[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            checks++;
            if (db[0] !== 1'b0) begin
                errors++;
                $display("FAIL rise0_early: cycle %0d got %b expected 0", k, db[0]);
            end
        end
        tick(1);
        checks++;
        if (db !== 21'h1 || rise !== '0) begin
            errors++;
            $display("FAIL rise0_level: got db %h rise %h expected 1/0", db, rise);
        end
        tick(1);
        checks++;
        if (rise !== 21'h1 || fall !== '0) begin
            errors++;
            $display("FAIL rise0_pulse: got rise %h fall %h expected 1/0", rise, fall);
        end
        tick(1);
        checks++;
        if (rise !== '0) begin
            errors++;
            $display("FAIL rise0_width: got %h expected 0", rise);
        end
    endtask

    task automatic test_bounce();
        settle();
        for (int c = 0; c < 40; c++) begin
            raw[3] = ((c / 3) % 2) == 0;
            tick(1);
            checks++;
            if (db[3] !== 1'b0 || rise[3] !== 1'b0 || fall[3] !== 1'b0) begin
                errors++;
                $display("FAIL bounce: cycle %0d got db %b rise %b fall %b expected 0",
                         c, db[3], rise[3], fall[3]);
            end
        end
        raw[3] = 1'b0;
        tick(15);
        checks++;
        if (db !== '0 || rise !== '0 || fall !== '0) begin
            errors++;
            $display("FAIL bounce_after: got db %h rise %h fall %h expected 0", db, rise, fall);
        end
    endtask

    task automatic test_restart();
        settle();
        raw[2] = 1'b1;
        tick(7);
        raw[2] = 1'b0;
        tick(1);
        raw[2] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            checks++;
            if (db[2] !== 1'b0) begin
                errors++;
                $display("FAIL restart_early: cycle %0d got %b expected 0", k, db[2]);
            end
        end
        tick(1);
        checks++;
        if (db !== 21'h4) begin
            errors++;
            $display("FAIL restart_level: got %h expected %h", db, 21'h4);
        end
        tick(1);
        checks++;
        if (rise !== 21'h4) begin
            errors++;
            $display("FAIL restart_pulse: got %h expected %h", rise, 21'h4);
        end
    endtask

    task automatic test_reset_mid();
        settle();
        raw[1] = 1'b1;
        tick(12);
        checks++;
        if (db !== 21'h2) begin
            errors++;
            $display("FAIL mid_qual: got %h expected %h", db, 21'h2);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (db !== '0 || rise !== '0 || fall !== '0) begin
            errors++;
            $display("FAIL mid_async: got db %h rise %h fall %h expected 0", db, rise, fall);
        end
        tick(2);
        rst_n = 1'b1;
        tick(9);
        checks++;
        if (db !== '0) begin
            errors++;
            $display("FAIL mid_early: got %h expected 0", db);
        end
        tick(1);
        checks++;
        if (db !== 21'h2) begin
            errors++;
            $display("FAIL mid_requal: got %h expected %h", db, 21'h2);
        end
        tick(1);
        checks++;
        if (rise !== 21'h2 || fall !== '0) begin
            errors++;
            $display("FAIL mid_rise: got rise %h fall %h expected 2/0", rise, fall);
        end
    endtask

    task automatic test_simultaneous();
        settle();
        raw[4] = 1'b1;
        tick(14);
        checks++;
        if (db !== 21'h10) begin
            errors++;
            $display("FAIL simul_setup: got %h expected %h", db, 21'h10);
        end
        raw = 21'h100000;
        tick(9);
        checks++;
        if (db !== 21'h10) begin
            errors++;
            $display("FAIL simul_early: got %h expected %h", db, 21'h10);
        end
        tick(1);
        checks++;
        if (db !== 21'h100000 || rise !== '0 || fall !== '0) begin
            errors++;
            $display("FAIL simul_level: got db %h rise %h fall %h expected 100000/0/0",
                     db, rise, fall);
        end
        tick(1);
        checks++;
        if (rise !== 21'h100000 || fall !== 21'h10) begin
            errors++;
            $display("FAIL simul_pulse: got rise %h fall %h expected 100000/10", rise, fall);
        end
        tick(1);
        checks++;
        if (rise !== '0 || fall !== '0) begin
            errors++;
            $display("FAIL simul_width: got rise %h fall %h expected 0", rise, fall);
        end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_bounce();
        test_restart();
        test_reset_mid();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
